// File: rtl/npu_axi_pkg.sv
// Shared AXI constants and types for the NPU data read arbiter.
// Optional build macro: NPU_RDARB_PRIO_EN (strict priority for ifmap).
package npu_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_32B   = 3'd5;

  typedef enum logic [1:0] {
    REQ_IFMAP   = 2'd0,
    REQ_WEIGHT  = 2'd1,
    REQ_VCUPARA = 2'd2,
    REQ_VCUCODE = 2'd3
  } req_idx_e;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_e;

endpackage

// File: rtl/npu_rr_arbiter.sv
// Combinational round-robin picker; search starts one past last grant.
// NPU_RDARB_PRIO_EN: requester 0 wins whenever it requests.
module npu_rr_arbiter
  import npu_axi_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] w_req;
  logic         w_hit;
  int           w_d;
  int           w_best;
  int           w_sel;

  always_comb begin
`ifdef NPU_RDARB_PRIO_EN
    w_req = req[0] ? {{(N-1){1'b0}}, 1'b1} : req;
`else
    w_req = req;
`endif
    w_hit  = 1'b0;
    w_best = N;
    w_sel  = 0;
    w_d    = 0;
    // distance from the slot after last, wrapping modulo N
    for (int i = 0; i < N; i++) begin
      w_d = (i + N - 1 - int'(last)) % N;
      if (w_req[i] && (w_d < w_best)) begin
        w_best = w_d;
        w_sel  = i;
        w_hit  = 1'b1;
      end
    end
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = w_hit && (w_sel == i);
    end
    idx = IDX_W'(w_sel);
  end

endmodule

// File: rtl/npu_dma_rd_arbiter.sv
// Shares the NPU data AXI read master between the read DMAs.
// NPU_RDARB_PRIO_EN: ifmap (requester 0) gets strict priority.
module npu_dma_rd_arbiter
  import npu_axi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 256,
  parameter int ID_WIDTH    = 10,
  parameter int OUTSTANDING = 8,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_arvalid,
  output logic [NUM_REQ-1:0]            req_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]          req_arlen,
  output logic [ID_WIDTH-1:0]           m_arid,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  output logic                          m_arlock,
  output logic [3:0]                    m_arcache,
  output logic [2:0]                    m_arprot,
  output logic [3:0]                    m_arqos,
  output logic                          m_aruser,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [ID_WIDTH-1:0]           m_rid,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic [NUM_REQ-1:0]            req_rvalid,
  input  logic [NUM_REQ-1:0]            req_rready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [1:0]                    req_rresp,
  output logic                          req_rlast,
  output logic                          err_bad_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  ar_state_e             r_state;
  ar_state_e             w_state_n;
  logic [IDX_W-1:0]      r_last;
  logic [CNT_W-1:0]      r_cnt [NUM_REQ];
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [ID_WIDTH-1:0]   r_arid;
  logic                  r_err;

  logic [NUM_REQ-1:0]    w_full;
  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [NUM_REQ-1:0]    w_inc;
  logic [NUM_REQ-1:0]    w_dec;
  logic [IDX_W-1:0]      w_gidx;
  logic [IDX_W-1:0]      w_ridx;
  logic                  w_grant;
  logic                  w_bad;
  logic                  w_rdone;
  logic                  w_cnt_nz;
  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [7:0]            w_len  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_addr[g] = req_araddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_len[g]  = req_arlen[g*8 +: 8];
  end

  always_comb begin
    w_cnt_nz = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_full[i] = (r_cnt[i] == CNT_W'(OUTSTANDING));
      w_cnt_nz  = w_cnt_nz | (r_cnt[i] != '0);
    end
  end

  assign w_elig = req_arvalid & ~w_full;

  npu_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req  (w_elig),
    .last (r_last),
    .gnt  (w_gnt),
    .idx  (w_gidx)
  );

  assign w_grant     = (r_state == AR_IDLE) && (|w_gnt);
  assign req_arready = (r_state == AR_IDLE) ? w_gnt : '0;

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      AR_IDLE:  if (|w_gnt) w_state_n = AR_ISSUE;
      AR_ISSUE: if (m_arready) w_state_n = AR_IDLE;
      default:  w_state_n = AR_IDLE;
    endcase
  end

  // a full RID at or above NUM_REQ is foreign: sink it and flag it
  assign w_ridx   = m_rid[IDX_W-1:0];
  assign w_bad    = (m_rid >= ID_WIDTH'(NUM_REQ));
  assign m_rready = w_bad | req_rready[w_ridx];
  assign w_rdone  = m_rvalid & m_rready & m_rlast & ~w_bad;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rvalid[i] = m_rvalid & ~w_bad & (w_ridx == IDX_W'(i));
      w_inc[i]      = w_grant & w_gnt[i];
      w_dec[i]      = w_rdone & (w_ridx == IDX_W'(i));
    end
  end

  assign req_rdata = m_rdata;
  assign req_rresp = m_rresp;
  assign req_rlast = m_rlast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= AR_IDLE;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arid    <= '0;
      r_err     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_grant) begin
        r_arvalid <= 1'b1;
        r_araddr  <= w_addr[w_gidx];
        r_arlen   <= w_len[w_gidx];
        r_arid    <= {{(ID_WIDTH-IDX_W){1'b0}}, w_gidx};
        r_last    <= w_gidx;
      end else if (r_arvalid && m_arready) begin
        r_arvalid <= 1'b0;
      end
      if (m_rvalid && w_bad) r_err <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_inc[i] && !w_dec[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  assign m_arvalid  = r_arvalid;
  assign m_araddr   = r_araddr;
  assign m_arlen    = r_arlen;
  assign m_arid     = r_arid;
  assign m_arsize   = AXI_SIZE_32B;
  assign m_arburst  = AXI_BURST_INCR;
  assign m_arlock   = 1'b0;
  assign m_arcache  = 4'd0;
  assign m_arprot   = 3'd0;
  assign m_arqos    = 4'd0;
  assign m_aruser   = 1'b0;
  assign err_bad_id = r_err;
  assign busy       = r_arvalid | w_cnt_nz;

endmodule
